// File: rtl/frame_ctrl.sv
// frame_ctrl: frame-rate game mode controller driven by the VGA timing generator.
//
// Produces a once-per-frame tick, debounces the two pushbuttons at frame rate,
// and runs the IDLE/PLAY/PAUSE/OVER mode machine, which only ever changes state
// on a frame boundary so the screen generator never sees a mid-frame mode switch.
//
// Ports:
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   col, row      current raster position from the timing generator
//   valid         visible-area flag (monitored only, affects nothing)
//   btn_start     raw asynchronous pushbutton, active-high
//   btn_pause     raw asynchronous pushbutton, active-high
//   game_over     single-cycle pulse from game logic, held pending until the next tick
//   frame_tick    one-cycle pulse per frame, the cycle after row==V_ACTIVE, col==0
//   mode          0=IDLE 1=PLAY 2=PAUSE 3=OVER
//   mode_changed  one-cycle pulse in the first cycle a new mode value is visible
//   frame_count   free-running 8-bit frame counter
//   blink         frame_count[5], toggles every 32 frames
module frame_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned OVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] col,
  input  logic [9:0] row,
  input  logic       valid,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       game_over,
  output logic       frame_tick,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic [7:0] frame_count,
  output logic       blink
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OC_W  = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES + 1) : 1;
  localparam logic [OC_W-1:0] OVER_LAST = OC_W'(OVER_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } mode_e;

  mode_e             state;
  mode_e             state_d;
  logic [OC_W-1:0]   over_cnt;
  logic [OC_W-1:0]   over_cnt_d;

  logic              start_meta;
  logic              start_sync;
  logic              pause_meta;
  logic              pause_sync;
  logic              prev_start;
  logic              prev_pause;
  logic              go_pend;

  logic              tick_c;
  logic              start_press_c;
  logic              pause_press_c;
  logic              go_pend_c;

  // valid and H_ACTIVE are intentionally not part of any decision.
  logic              unused_ok;
  assign unused_ok = valid ^ (col == 10'(H_ACTIVE));

  // Start-of-vertical-blank marker; occurs exactly once per frame.
  assign tick_c = (row == 10'(V_ACTIVE)) && (col == 10'd0);

  // Rising edge of the synchronized level, judged only frame to frame.
  assign start_press_c = frame_tick & start_sync & ~prev_start;
  assign pause_press_c = frame_tick & pause_sync & ~prev_pause;

  // A pulse coincident with the tick survives into the next frame.
  assign go_pend_c = game_over | (go_pend & ~frame_tick);

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      over_cnt <= '0;
    end else begin
      state    <= state_d;
      over_cnt <= over_cnt_d;
    end
  end

  // Next-state logic, evaluated only in frame_tick cycles.
  always_comb begin
    state_d    = state;
    over_cnt_d = over_cnt;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (start_press_c) state_d = PLAY;
        end
        PLAY: begin
          if (go_pend) begin
            state_d    = OVER;
            over_cnt_d = '0;
          end else if (pause_press_c) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (pause_press_c)      state_d = PLAY;
          else if (start_press_c) state_d = IDLE;
        end
        OVER: begin
          if (start_press_c)              state_d = IDLE;
          else if (over_cnt >= OVER_LAST) state_d = IDLE;
          else                            over_cnt_d = over_cnt + OC_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizers, frame-rate debounce history, pending flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_meta   <= 1'b0;
      start_sync   <= 1'b0;
      pause_meta   <= 1'b0;
      pause_sync   <= 1'b0;
      prev_start   <= 1'b0;
      prev_pause   <= 1'b0;
      go_pend      <= 1'b0;
      frame_tick   <= 1'b0;
      mode_changed <= 1'b0;
      frame_count  <= '0;
    end else begin
      start_meta   <= btn_start;
      start_sync   <= start_meta;
      pause_meta   <= btn_pause;
      pause_sync   <= pause_meta;
      go_pend      <= go_pend_c;
      frame_tick   <= tick_c;
      mode_changed <= (state_d != state);
      if (frame_tick) begin
        prev_start  <= start_sync;
        prev_pause  <= pause_sync;
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

  assign mode  = state;
  assign blink = frame_count[5];

endmodule
